// File: rtl/dsi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dsi_pkg
// Description : Shared types, constants and the header ECC helper for the
//               DSI packetizer slice.
//               Contents: FSM state enum, DCS data-type codes, CRC-16
//               constants, dsi_ecc() 6-bit Hamming over the 24 header bits.
// Revision    : 1.0 - initial release
// ============================================================================
package dsi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HDR     = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_CRC     = 3'd3,
      ST_END     = 3'd4,
      ST_GAP     = 3'd5
   } dsi_state_e;

   // DCS data types (DT field, VC excluded)
   localparam logic [5:0] DT_DCS_SHORT_WR0 = 6'h05;
   localparam logic [5:0] DT_DCS_SHORT_WR1 = 6'h15;
   localparam logic [5:0] DT_DCS_LONG_WR   = 6'h39;

   // Reflected CCITT CRC: LSB-first shift with 0x8408
   localparam logic [15:0] CRC_INIT = 16'hFFFF;
   localparam logic [15:0] CRC_POLY = 16'h8408;

   // Header ECC. d[7:0] = DI (bit0 = D0), d[23:8] = WC. P7:P6 are zero and
   // are added by the caller when the byte is formed.
   function automatic logic [5:0] dsi_ecc(input logic [23:0] d);
      logic [5:0] p;
      p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
      p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
      p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
      p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
      p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
      p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
      return p;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dsi_packetizer_if.sv
`default_nettype none
// ============================================================================
// Module      : dsi_packetizer_if
// Description : Bundles the command, payload and mipi-side byte bus.
//               slave  : the packetizer (takes commands/payload, drives mipi)
//               master : the display controller / mipi model around it
//               cmd_*  : command valid/ready with long flag, DI and WC
//               pl_*   : payload byte valid/ready
//               b_req, d_req, d_out, d_ack : mipi bus/data request bus
// Revision    : 1.0 - initial release
// ============================================================================
interface dsi_packetizer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_long;
   logic [7:0]  cmd_di;
   logic [15:0] cmd_wc;
   logic [7:0]  pl_data;
   logic        pl_valid;
   logic        pl_ready;
   logic        b_req;
   logic        d_req;
   logic [7:0]  d_out;
   logic        d_ack;

   modport slave (
      input  cmd_valid, cmd_long, cmd_di, cmd_wc, pl_data, pl_valid, d_ack,
      output cmd_ready, pl_ready, b_req, d_req, d_out
   );

   modport master (
      output cmd_valid, cmd_long, cmd_di, cmd_wc, pl_data, pl_valid, d_ack,
      input  cmd_ready, pl_ready, b_req, d_req, d_out
   );
endinterface
`default_nettype wire

// File: rtl/dsi_crc16.sv
`default_nettype none
// ============================================================================
// Module      : dsi_crc16
// Description : Byte-wide reflected CRC-16 (x^16+x^12+x^5+1) register.
//               clk, rst (sync, active-low) ; init : load CRC_INIT
//               en : fold d[7:0] in LSB-first ; crc : current remainder
// Revision    : 1.0 - initial release
// ============================================================================
module dsi_crc16
   import dsi_pkg::*;
(
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic        init,
   input  wire logic        en,
   input  wire logic [7:0]  d,
   output      logic [15:0] crc
);

   logic [15:0] crc_q;
   logic [15:0] crc_d;

   always_comb begin
      crc_d = crc_q;
      if (init) begin
         crc_d = CRC_INIT;
      end else if (en) begin
         for (int i = 0; i < 8; i++) begin
            if (crc_d[0] ^ d[i]) crc_d = (crc_d >> 1) ^ CRC_POLY;
            else                 crc_d = crc_d >> 1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) crc_q <= CRC_INIT;
      else      crc_q <= crc_d;
   end

   assign crc = crc_q;

endmodule
`default_nettype wire

// File: rtl/dsi_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : dsi_packetizer
// Description : Builds DSI short/long packets (header + ECC, payload, CRC-16)
//               and streams them byte-by-byte to the mipi lane transmitter.
//               clk, rst (sync, active-low)
//               bus      : command / payload / mipi byte bus (slave view)
//               underrun : payload byte missing while in the payload phase
//               busy     : command accepted and gap not yet finished
// Revision    : 1.0 - initial release
// ============================================================================
module dsi_packetizer
   import dsi_pkg::*;
#(
   parameter int GAP_CYCLES = 2
) (
   input  wire logic      clk,
   input  wire logic      rst,
   dsi_packetizer_if.slave bus,
   output      logic      underrun,
   output      logic      busy
);

   localparam int              GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   dsi_state_e        state_q, state_d;
   logic [1:0]        idx_q,   idx_d;    // byte index inside HDR / CRC
   logic [15:0]       cnt_q,   cnt_d;    // payload bytes transferred
   logic [GAP_W-1:0]  gap_q,   gap_d;
   logic [7:0]        di_q,    di_d;
   logic [15:0]       wc_q,    wc_d;
   logic              long_q,  long_d;
   logic [5:0]        ecc_q,   ecc_d;

   logic        cmd_ready;
   logic        pl_ready;
   logic        b_req;
   logic        d_req;
   logic [7:0]  d_out;
   logic        crc_init;
   logic        crc_en;
   logic [15:0] crc;

   dsi_crc16 u_crc (
      .clk  (clk),
      .rst  (rst),
      .init (crc_init),
      .en   (crc_en),
      .d    (bus.pl_data),
      .crc  (crc)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      gap_d    = gap_q;
      di_d     = di_q;
      wc_d     = wc_q;
      long_d   = long_q;
      ecc_d    = ecc_q;
      cmd_ready = 1'b0;
      pl_ready  = 1'b0;
      b_req     = 1'b0;
      d_req     = 1'b0;
      d_out     = 8'h00;
      underrun  = 1'b0;
      crc_init  = 1'b0;
      crc_en    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (bus.cmd_valid) begin
               di_d     = bus.cmd_di;
               wc_d     = bus.cmd_wc;
               long_d   = bus.cmd_long;
               ecc_d    = dsi_ecc({bus.cmd_wc, bus.cmd_di});
               idx_d    = 2'd0;
               crc_init = 1'b1;
               state_d  = ST_HDR;
            end
         end

         ST_HDR: begin
            b_req = 1'b1;
            d_req = 1'b1;
            case (idx_q)
               2'd0:    d_out = di_q;
               2'd1:    d_out = wc_q[7:0];
               2'd2:    d_out = wc_q[15:8];
               default: d_out = {2'b00, ecc_q};
            endcase
            if (bus.d_ack) begin
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  idx_d = 2'd0;
                  cnt_d = 16'd0;
                  if (!long_q)           state_d = ST_END;
                  else if (wc_q == 16'd0) state_d = ST_CRC;
                  else                   state_d = ST_PAYLOAD;
               end
            end
         end

         ST_PAYLOAD: begin
            // Straight pass-through; a missing byte stalls the burst rather
            // than truncating the packet.
            b_req    = 1'b1;
            d_req    = bus.pl_valid;
            d_out    = bus.pl_data;
            pl_ready = bus.d_ack && bus.pl_valid;
            underrun = !bus.pl_valid;
            if (pl_ready) begin
               crc_en = 1'b1;
               cnt_d  = cnt_q + 16'd1;
               // cnt_q + 1 never exceeds wc_q, so WC=65535 cannot wrap here.
               if ((cnt_q + 16'd1) == wc_q) begin
                  idx_d   = 2'd0;
                  state_d = ST_CRC;
               end
            end
         end

         ST_CRC: begin
            b_req = 1'b1;
            d_req = 1'b1;
            d_out = idx_q[0] ? crc[15:8] : crc[7:0];
            if (bus.d_ack) begin
               if (idx_q[0]) state_d = ST_END;
               else          idx_d   = 2'd1;
            end
         end

         ST_END: begin
            b_req   = 1'b1;
            gap_d   = '0;
            state_d = ST_GAP;
         end

         ST_GAP: begin
            if (gap_q == GAP_LAST) state_d = ST_IDLE;
            else                   gap_d   = gap_q + 1'b1;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         idx_q   <= 2'd0;
         cnt_q   <= 16'd0;
         gap_q   <= '0;
         di_q    <= 8'h00;
         wc_q    <= 16'h0000;
         long_q  <= 1'b0;
         ecc_q   <= 6'h00;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         di_q    <= di_d;
         wc_q    <= wc_d;
         long_q  <= long_d;
         ecc_q   <= ecc_d;
      end
   end

   assign busy          = (state_q != ST_IDLE);
   assign bus.cmd_ready = cmd_ready;
   assign bus.pl_ready  = pl_ready;
   assign bus.b_req     = b_req;
   assign bus.d_req     = d_req;
   assign bus.d_out     = d_out;

endmodule
`default_nettype wire

// File: doc/dsi_packetizer.md
# dsi_packetizer

Assembles MIPI DSI short and long packets and streams them byte-by-byte into the `mipi` lane transmitter over its `b_req`/`d_req`/`d_in`/`d_ack` bus. It sits directly upstream of `mipi`: the display controller issues one command (data identifier + word count) plus an optional payload byte stream. The block inserts the header ECC and long-packet CRC-16, and frames each packet in one HS burst. Command and payload inputs use valid/ready handshakes; the output side obeys the `mipi` bus-request/data-request protocol.

## Interface
- `GAP_CYCLES`, 2: idle cycles enforced after `b_req` falls before the next command is accepted (≥1).
- `clk`  input  1  system clock, shared with `mipi`.
- `rst`  input  1  synchronous reset, active-low (0 = reset).
- `cmd_valid`  input  1  command present.
- `cmd_ready`  output  1  command accepted on a cycle with `cmd_valid && cmd_ready`.
- `cmd_long`  input  1  1 = long packet; 0 = short packet.
- `cmd_di`  input  8  data identifier, {VC[1:0], DT[5:0]}, sent as-is.
- `cmd_wc`  input  16  long: payload byte count; short: {data1, data0}.
- `pl_data`  input  8  payload byte.
- `pl_valid`  input  1  payload byte present.
- `pl_ready`  output  1  payload byte consumed this cycle.
- `b_req`  output  1  bus request to `mipi` (HS burst envelope).
- `d_req`  output  1  data request to `mipi`.
- `d_out`  output  8  byte to `mipi` (`d_in`).
- `d_ack`  input  1  `mipi` took `d_out` on this edge.
- `underrun`  output  1  one-cycle pulse: payload not available when needed.
- `busy`  output  1  high from command accept until end of GAP.

## Operation
- States: IDLE → HDR → (PAYLOAD → CRC, long only) → END → GAP → IDLE.
- IDLE: `cmd_ready`=1. On accept, latch `cmd_di`, `cmd_wc`, `cmd_long`; compute ECC; go HDR.
- HDR: emit DI, WC[7:0], WC[15:8], ECC (4 bytes).
  - After ECC, a short packet goes to END.
  - A long packet goes to PAYLOAD, or straight to CRC if WC=0.
- ECC: MIPI DSI 6-bit Hamming over the 24 header bits (DI bit0 = D0); P7:P6 = 0.
- PAYLOAD: pass-through.
  - `d_out`=`pl_data`, `d_req`=`pl_valid`, `pl_ready`=`d_ack && pl_valid`.
  - 16-bit counter counts transferred bytes; leaves for CRC after the WC-th transfer.
- CRC: polynomial x^16+x^12+x^5+1, LSB-first (reflected 0x8408), init 0xFFFF, no final XOR.
  - Updated on each payload transfer.
  - Sent low byte then high byte. WC=0 sends FF FF.
- Byte transfer rule: a byte is transferred on a rising edge with `d_req && d_ack`. `d_out` is stable while `d_req`=1 and un-acked.
- END: `d_req`=0 and `b_req`=1 for one cycle, then `b_req`=0 → GAP.
- GAP: count GAP_CYCLES with `cmd_ready`=0, then go IDLE.
- Underrun: if `pl_valid`=0 in PAYLOAD, `d_req` drops and `underrun` pulses each such cycle. The packet continues when data returns; it is never truncated.
- `pl_ready`=0 outside PAYLOAD; excess payload bytes are left unconsumed.

## Timing
- Reset (rst=0 at an edge), next cycle:
  - outputs: `b_req`=`d_req`=`pl_ready`=`underrun`=`busy`=0, `d_out`=0x00, `cmd_ready`=1.
  - internals: state IDLE, counters cleared, CRC=0xFFFF.
- Reset mid-packet: same values; the packet is abandoned and `b_req` falls immediately.
- Command accept at edge N: at N+1, `b_req`=1, `d_req`=1, `d_out`=DI.
- With `d_ack` held high, one byte per cycle with no bubbles, including across HDR→PAYLOAD→CRC.
- Short packet: 4 transfer cycles, 1 END cycle, GAP_CYCLES; `cmd_ready` returns at N+6+GAP_CYCLES with continuous ack.
- `d_req` falls the cycle after the last ack; `b_req` falls one cycle later.
- WC=65535 is supported: the counter is 16-bit, compared against latched WC, with no wrap before the match.

## Structure
- Package `dsi_pkg`:
  - state enum;
  - DT constants (0x05 DCS short write no param, 0x15 with param, 0x39 DCS long write);
  - CRC_INIT=16'hFFFF, CRC_POLY=16'h8408;
  - function `dsi_ecc(input [23:0])`.
- Sub-module `dsi_crc16`: byte-wide CRC register with `init`, `en`, `d[7:0]`, `crc[15:0]`.

## Test plan
- Short packet DI=0x05, WC=0x0011, ack always high → bytes 05 11 00 36; `b_req` spans exactly 5 cycles.
- Short packet DI=0x05, WC=0x0029 → 05 29 00 1C.
- Long packet DI=0x39, WC=9, payload ASCII "123456789" → header ECC per `dsi_ecc`, then 9 bytes, then 91 6F.
- Long packet WC=0 → 4 header bytes then FF FF; `pl_ready` never asserts.
- Payload gap:
  - `pl_valid` low for 3 cycles mid-payload → `d_req` low and `underrun` high for those 3 cycles; CRC unchanged versus the no-gap run.
  - Random `d_ack` stalls → identical byte sequence.
- Assert rst=0 during the payload → next cycle `b_req`=`d_req`=0 and `cmd_ready`=1; a following short packet is correct; back-to-back commands keep `b_req` low ≥ GAP_CYCLES.
